// File: rtl/uart_axil_ctrl.sv
//------------------------------------------------------------------------------
// uart_axil_ctrl : AXI4-Lite register front-end for a FIFO-buffered UART core
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_axil_ctrl #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [7:0]                        uart_rx_data,
  input  logic                              uart_empty,
  output logic                              uart_rd_en,
  output logic [7:0]                        uart_tx_data,
  output logic                              uart_wr_en,
  input  logic                              uart_full,
  output logic                              uart_enable_rx,
  output logic                              uart_enable_tx,
  output logic                              Interrupt
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] c_addr_rxdata = 2'd0;
  localparam logic [1:0] c_addr_txdata = 2'd1;
  localparam logic [1:0] c_addr_stat   = 2'd2;
  localparam logic [1:0] c_addr_ctrl   = 2'd3;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  logic [0:0]                    r_wstate;
  logic [0:0]                    r_rstate;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [1:0]                    r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [7:0]                    r_tx_data;
  logic                          r_wr_en;
  logic                          r_en_rx;
  logic                          r_en_tx;
  logic                          r_ie;
  logic                          r_irq;

  logic                          w_wr_hs;
  logic                          w_rd_hs;
  logic                          w_arready;
  logic [1:0]                    w_waddr;
  logic [1:0]                    w_raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic                          w_unused;

  assign w_waddr = S_AXI_AWADDR[3:2];
  assign w_raddr = S_AXI_ARADDR[3:2];

  // Address and data are accepted together only; reset masks both ready paths
  assign w_wr_hs   = !S_AXI_ARESET && (r_wstate == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_arready = !S_AXI_ARESET && (r_rstate == R_IDLE);
  assign w_rd_hs   = w_arready && S_AXI_ARVALID;

  assign S_AXI_AWREADY = w_wr_hs;
  assign S_AXI_WREADY  = w_wr_hs;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

  assign uart_tx_data   = r_tx_data;
  assign uart_wr_en     = r_wr_en;
  assign uart_enable_rx = r_en_rx;
  assign uart_enable_tx = r_en_tx;
  assign Interrupt      = r_irq;

  // Pop lands in the AR handshake cycle so the FWFT head is captured and consumed together
  assign uart_rd_en = w_rd_hs && (w_raddr == c_addr_rxdata) && !uart_empty;

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      c_addr_rxdata: begin
        if (!uart_empty) begin
          w_rdata[7:0] = uart_rx_data;
        end
      end
      c_addr_stat: begin
        w_rdata[0] = !uart_empty;
        w_rdata[1] = uart_full;
        w_rdata[2] = r_ie;
      end
      c_addr_ctrl: begin
        w_rdata[0] = r_en_rx;
        w_rdata[1] = r_en_tx;
        w_rdata[4] = r_ie;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_wstate  <= W_IDLE;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_resp_okay;
      r_tx_data <= 8'h00;
      r_wr_en   <= 1'b0;
      r_en_rx   <= 1'b0;
      r_en_tx   <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_hs) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= c_resp_okay;
            if (S_AXI_WSTRB[0]) begin
              case (w_waddr)
                c_addr_txdata: begin
                  if (uart_full) begin
                    r_bresp <= c_resp_slverr;
                  end else begin
                    r_tx_data <= S_AXI_WDATA[7:0];
                    r_wr_en   <= 1'b1;
                  end
                end
                c_addr_ctrl: begin
                  r_en_rx <= S_AXI_WDATA[0];
                  r_en_tx <= S_AXI_WDATA[1];
                  r_ie    <= S_AXI_WDATA[4];
                end
                default: ;
              endcase
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rresp  <= c_resp_okay;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_hs) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rresp  <= c_resp_okay;
            r_rdata  <= w_rdata;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ie && !uart_empty;
    end
  end

  // Address LSBs, upper data byte lanes and upper strobes have no function here
  assign w_unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

endmodule

`default_nettype wire

// File: tb/tb_uart_axil_ctrl.sv
//------------------------------------------------------------------------------
// tb_uart_axil_ctrl : directed self-checking bench for uart_axil_ctrl
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_axil_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  rx_data;
  logic        empty;
  logic        rd_en;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic        full;
  logic        en_rx;
  logic        en_tx;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  logic [7:0] last_tx = 8'h00;

  always #5 clk = ~clk;

  uart_axil_ctrl #(
    .C_S_AXI_ADDR_WIDTH (4),
    .C_S_AXI_DATA_WIDTH (32)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESET   (rst),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .uart_rx_data   (rx_data),
    .uart_empty     (empty),
    .uart_rd_en     (rd_en),
    .uart_tx_data   (tx_data),
    .uart_wr_en     (wr_en),
    .uart_full      (full),
    .uart_enable_rx (en_rx),
    .uart_enable_tx (en_tx),
    .Interrupt      (irq)
  );

  // Strobe monitor samples mid-cycle, between input changes and the next rising edge
  always @(negedge clk) begin
    #3;
    if (wr_en) begin
      wr_cnt++;
      last_tx = tx_data;
    end
    if (rd_en) rd_cnt++;
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (awready !== 1'b1) begin
      failures++;
      $display("FAIL wr_addr_accept got awready=%b need 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (bvalid !== 1'b1) begin
      failures++;
      $display("FAIL wr_bvalid got %b need 1", bvalid);
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL rd_addr_accept got arready=%b need 1", arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rd_rvalid got %b need 1", rvalid);
    end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    rx_data = 8'h00; empty = 1'b1; full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, bvalid, rvalid, bresp, rresp} !== 8'h00) begin
      failures++;
      $display("FAIL reset_handshake got aw=%b w=%b b=%b r=%b bresp=%b rresp=%b need all 0",
               awready, wready, bvalid, rvalid, bresp, rresp);
    end
    checks++;
    if (rdata !== 32'h0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got rdata=%h tx=%h need 0/0", rdata, tx_data);
    end
    checks++;
    if ({rd_en, wr_en, en_rx, en_tx, irq} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rd=%b wr=%b erx=%b etx=%b irq=%b need 0",
               rd_en, wr_en, en_rx, en_tx, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_arready got %b need 1", arready);
    end
  endtask

  task automatic test_ctrl();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(4'hC, 32'h0000_0013, 4'hF, resp);
    checks++;
    if (resp !== 2'b00) begin
      failures++; $display("FAIL ctrl_bresp got %b need 00", resp);
    end
    axi_read(4'hC, d, resp);
    checks++;
    if (d !== 32'h13 || resp !== 2'b00) begin
      failures++; $display("FAIL ctrl_read got %h/%b need 00000013/00", d, resp);
    end
    checks++;
    if (en_rx !== 1'b1 || en_tx !== 1'b1) begin
      failures++; $display("FAIL ctrl_enables got rx=%b tx=%b need 1/1", en_rx, en_tx);
    end
    // STAT with IE set, FIFO empty, not full
    axi_read(4'h8, d, resp);
    checks++;
    if (d !== 32'h4) begin
      failures++; $display("FAIL stat_ie got %h need 00000004", d);
    end
    // Writes to read-only STAT are ignored
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, resp);
    axi_read(4'hC, d, resp);
    checks++;
    if (d !== 32'h13) begin
      failures++; $display("FAIL stat_write_ignored got ctrl=%h need 00000013", d);
    end
  endtask

  task automatic test_tx();
    logic [1:0]  resp;
    logic [31:0] d;
    int          w0;
    full = 1'b0;
    w0 = wr_cnt;
    axi_write(4'h4, 32'h0000_00A5, 4'hF, resp);
    checks++;
    if (resp !== 2'b00 || wr_cnt - w0 !== 1 || last_tx !== 8'hA5) begin
      failures++;
      $display("FAIL tx_push got resp=%b pulses=%0d data=%h need 00/1/a5", resp, wr_cnt - w0, last_tx);
    end
    full = 1'b1;
    w0 = wr_cnt;
    axi_write(4'h4, 32'h0000_005A, 4'hF, resp);
    checks++;
    if (resp !== 2'b10 || wr_cnt - w0 !== 0 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL tx_full got resp=%b pulses=%0d data=%h need 10/0/a5", resp, wr_cnt - w0, tx_data);
    end
    full = 1'b0;
    w0 = wr_cnt;
    axi_write(4'h4, 32'h0000_0077, 4'hE, resp);
    checks++;
    if (resp !== 2'b00 || wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL tx_nostrb got resp=%b pulses=%0d need 00/0", resp, wr_cnt - w0);
    end
    axi_read(4'h4, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== 2'b00) begin
      failures++; $display("FAIL tx_readback got %h/%b need 00000000/00", d, resp);
    end
  endtask

  task automatic test_rx();
    logic [1:0]  resp;
    logic [31:0] d;
    int          r0;
    rx_data = 8'h3C; empty = 1'b0;
    r0 = rd_cnt;
    axi_read(4'h0, d, resp);
    checks++;
    if (d !== 32'h3C || resp !== 2'b00 || rd_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL rx_pop got %h/%b pulses=%0d need 0000003c/00/1", d, resp, rd_cnt - r0);
    end
    // STAT with data present and TX full, IE still set
    full = 1'b1;
    axi_read(4'h8, d, resp);
    checks++;
    if (d !== 32'h7) begin
      failures++; $display("FAIL stat_all got %h need 00000007", d);
    end
    full = 1'b0;
    empty = 1'b1;
    r0 = rd_cnt;
    axi_read(4'h3, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== 2'b00 || rd_cnt - r0 !== 0) begin
      failures++;
      $display("FAIL rx_empty got %h/%b pulses=%0d need 00000000/00/0", d, resp, rd_cnt - r0);
    end
  endtask

  task automatic test_irq();
    logic [1:0] resp;
    @(negedge clk);
    empty = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_idle got %b need 0", irq);
    end
    @(negedge clk);
    empty = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_latency got %b need 0 before edge", irq);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_raise got %b need 1", irq);
    end
    axi_write(4'hC, 32'h0000_0003, 4'hF, resp);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear got %b need 0", irq);
    end
    @(negedge clk);
    empty = 1'b1;
  endtask

  task automatic test_stall();
    logic       ok;
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h0000_0012; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (awready !== 1'b0 || wready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL aw_only got early ready=%b need 1", ok);
    end
    wvalid = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      failures++; $display("FAIL aw_w_join got aw=%b w=%b need 1/1", awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (wready !== 1'b0 || awready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL w_only got early ready=%b need 1", ok);
    end
    araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rvalid !== 1'b1 || rdata !== 32'h12 || arready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++; $display("FAIL r_hold got stable=%b rdata=%h need 1/00000012", ok, rdata);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL r_release got rvalid=%b arready=%b need 0/1", rvalid, arready);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  resp;
    logic [31:0] d;
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h0000_0011; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      failures++; $display("FAIL simul_ready got aw=%b ar=%b need 1/1", awready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h4 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL simul_resp got b=%b r=%b rdata=%h bresp=%b need 1/1/00000004/00",
               bvalid, rvalid, rdata, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(4'hC, d, resp);
    checks++;
    if (d !== 32'h11) begin
      failures++; $display("FAIL simul_ctrl got %h need 00000011", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  resp;
    logic [31:0] d;
    int          r0;
    int          w0;
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h0000_0013; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      failures++; $display("FAIL mid_pending got b=%b r=%b need 1/1", bvalid, rvalid);
    end
    @(negedge clk);
    rst = 1'b1;
    rx_data = 8'h55; empty = 1'b0;
    araddr = 4'h0; arvalid = 1'b1;
    awaddr = 4'h4; wdata = 32'h0000_0099; awvalid = 1'b1; wvalid = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL mid_reset got b=%b r=%b irq=%b need 0/0/0", bvalid, rvalid, irq);
    end
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    empty = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL mid_strobes got pops=%0d pushes=%0d need 0/0", rd_cnt - r0, wr_cnt - w0);
    end
    axi_read(4'hC, d, resp);
    checks++;
    if (d !== 32'h0 || en_rx !== 1'b0 || en_tx !== 1'b0) begin
      failures++; $display("FAIL mid_ctrl got %h rx=%b tx=%b need 00000000/0/0", d, en_rx, en_tx);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_tx();
    test_rx();
    test_irq();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
